// File: rtl/uart_tx_engine_if.sv
// rtl/uart_tx_engine_if.sv - packetiser-to-UART-transmitter start/busy/done handshake bundle
// The packetiser drives data/start as master; the transmit engine is the slave.
interface uart_tx_engine_if;
  logic [7:0] TX_Data_in;
  logic       TX_Start;
  logic       TX_out;
  logic       TX_Busy;
  logic       TX_Done;

  modport master (
    output TX_Data_in,
    output TX_Start,
    input  TX_out,
    input  TX_Busy,
    input  TX_Done
  );

  modport slave (
    input  TX_Data_in,
    input  TX_Start,
    output TX_out,
    output TX_Busy,
    output TX_Done
  );
endinterface

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmitter, 8 data bits LSB first, one stop bit, internal baud divider
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic            clk,
  input  logic            reset_b,
  uart_tx_engine_if.slave tx_if
);

  localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] START_BIT  = 3'd1;
  localparam logic [2:0] DATA_BITS  = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY_BIT = 3'd3;
`endif
  localparam logic [2:0] STOP_BIT   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    idx_q,   idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q,    tx_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_MAX);

  // Line level for the next bit is computed here so TX_out stays a plain flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (tx_if.TX_Start) begin
          shift_d = tx_if.TX_Data_in;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_if.TX_Data_in;
`endif
          state_d = START_BIT;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA_BITS;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY_BIT;
            tx_d    = parity_q;
`else
            state_d = STOP_BIT;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP_BIT;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_if.TX_out  = tx_q;
  assign tx_if.TX_Busy = busy_q;
  assign tx_if.TX_Done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - scoreboard bench for uart_tx_engine at CLKS_PER_BIT=4
module tb_uart_tx_engine;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } exp_t;

  logic clk;
  logic reset_b;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   done_seen;
  int   exp_done;
  int   unexpected;
  int   last_done_cyc;
  exp_t exp_q[$];

  uart_tx_engine_if u_if ();

  uart_tx_engine #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .tx_if   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (reset_b && u_if.TX_Done === 1'b1) done_seen <= done_seen + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (u_if.TX_Busy === 1'b0) seen = 1'b1;
    end
    check("wait_idle", seen, 1);
  endtask

  task automatic send(input logic [7:0] b, input bit expect_done);
    wait_idle();
    exp_q.push_back('{data: b, b2b: 1'b0});
    if (expect_done) exp_done++;
    @(posedge clk); #1;
    u_if.TX_Data_in = b;
    u_if.TX_Start   = 1'b1;
    @(posedge clk); #1;
    u_if.TX_Start   = 1'b0;
  endtask

  // Monitor: decodes every frame on the line and checks it against the queued byte.
  initial begin : monitor
    exp_t        e;
    bit          ok;
    bit          aborted;
    int          start_cyc;
    logic [10:0] fb;
    forever begin
      @(negedge clk);
      if (reset_b && u_if.TX_Busy === 1'b1 && u_if.TX_out === 1'b0) begin
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          unexpected++;
          for (int t = 0; t < 20 * C && u_if.TX_Busy === 1'b1; t++) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          if (e.b2b) check("b2b_start_after_done", start_cyc - last_done_cyc, 1);
`ifdef UART_TX_PARITY_EN
          fb = {1'b1, ^e.data, e.data, 1'b0};
`else
          fb = {2'b11, e.data, 1'b0};
`endif
          aborted = 1'b0;
          ok      = 1'b1;
          for (int i = 0; i < NB * C && !aborted; i++) begin
            if (i != 0) @(negedge clk);
            if (!reset_b) begin
              aborted = 1'b1;
            end else begin
              if (u_if.TX_out !== fb[i / C] || u_if.TX_Busy !== 1'b1 || u_if.TX_Done !== 1'b0) ok = 1'b0;
              if (i % C == C - 1) begin
                check($sformatf("frame_%02h_bit%0d", e.data, i / C), ok, 1);
                ok = 1'b1;
              end
            end
          end
          if (!aborted) begin
            @(negedge clk);
            if (reset_b) begin
              check($sformatf("frame_%02h_done_busy_tx", e.data),
                    {u_if.TX_Done, u_if.TX_Busy, u_if.TX_out}, 3'b101);
              if (e.b2b) check("done_spacing", cyc - last_done_cyc, NB * C + 1);
              last_done_cyc = cyc;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit ok;
    bit seen;
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    done_seen     = 0;
    exp_done      = 0;
    unexpected    = 0;
    last_done_cyc = -1000;
    reset_b         = 1'b0;
    u_if.TX_Start   = 1'b0;
    u_if.TX_Data_in = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {u_if.TX_out, u_if.TX_Busy, u_if.TX_Done}, 3'b100);
    #1 reset_b = 1'b1;
    ok = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (u_if.TX_out !== 1'b1 || u_if.TX_Busy !== 1'b0 || u_if.TX_Done !== 1'b0) ok = 1'b0;
    end
    check("idle_20_cycles", ok, 1);

    // 0x55 -> line 0,1,0,1,0,1,0,1,0,1
    send(8'h55, 1'b1);

    // 0xA3 with a stray request carrying 0xFF at cycle 12; data bits 1,1,0,0,0,1,0,1
    send(8'hA3, 1'b1);
    repeat (11) @(posedge clk);
    #1;
    u_if.TX_Data_in = 8'hFF;
    u_if.TX_Start   = 1'b1;
    @(posedge clk); #1;
    u_if.TX_Start   = 1'b0;

    // Back-to-back 0x00 then 0xFF with TX_Start held high
    wait_idle();
    exp_q.push_back('{data: 8'h00, b2b: 1'b0});
    exp_q.push_back('{data: 8'hFF, b2b: 1'b1});
    exp_done += 2;
    @(posedge clk); #1;
    u_if.TX_Data_in = 8'h00;
    u_if.TX_Start   = 1'b1;
    @(posedge clk); #1;
    u_if.TX_Data_in = 8'hFF;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (u_if.TX_Done === 1'b1) seen = 1'b1;
    end
    check("b2b_first_done_seen", seen, 1);
    @(posedge clk); #1;
    u_if.TX_Start = 1'b0;

    // Reset during data bit 3 of 0x0F: frame abandoned, no done
    send(8'h0F, 1'b0);
    repeat (17) @(posedge clk);
    #2;
    reset_b = 1'b0;
    #1;
    check("midreset_outputs", {u_if.TX_out, u_if.TX_Busy, u_if.TX_Done}, 3'b100);
    repeat (2) @(posedge clk);
    #2;
    reset_b = 1'b1;
    check("midreset_line_high", u_if.TX_out, 1);

    send(8'h81, 1'b1);

`ifdef UART_TX_PARITY_EN
    // 0x07 -> parity 1, 0x03 -> parity 0
    send(8'h07, 1'b1);
    send(8'h03, 1'b1);
`endif

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_pulse_count", done_seen, exp_done);
    check("unexpected_frames", unexpected, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

UART transmitter: serialises one 8-bit byte per request into a standard asynchronous frame (start bit, 8 data bits LSB first, optional parity bit, stop bit) on a single idle-high line. It is the transmit counterpart of the acoustics board's UART receive path. It is driven by the comms packetiser through a start/busy/done handshake. Bit timing comes from an internal clock-cycle divider, so no external baud tick is needed.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset_b` input 1: asynchronous, active-low reset.
- `TX_Data_in` input 8: byte to send. Sampled only on the accept edge.
- `TX_Start` input 1: transmit request. Level-sampled in IDLE only.
- `TX_out` output 1: serial line, registered. Idle level is 1.
- `TX_Busy` output 1: high while a frame is in progress (every state except IDLE), registered.
- `TX_Done` output 1: one-cycle pulse when a frame completes, registered.

## Operation
- FSM states:
  - IDLE
  - START_BIT
  - DATA_BITS
  - PARITY_BIT (present only with `UART_TX_PARITY_EN`)
  - STOP_BIT
- IDLE:
  - `TX_out`=1, `TX_Busy`=0, baud counter=0, bit index=0.
  - If `TX_Start`=1: latch `TX_Data_in` into the shift register, set parity accumulator to the XOR of the byte, go to START_BIT.
- START_BIT: `TX_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA_BITS.
- DATA_BITS:
  - `TX_out` = shift register bit 0.
  - After each `CLKS_PER_BIT` cycles, shift right and increment the 3-bit bit index.
  - After the 8th bit (index 7 expiring), go to PARITY_BIT or STOP_BIT.
- PARITY_BIT: `TX_out` = even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles, then go to STOP_BIT.
- STOP_BIT: `TX_out`=1 for `CLKS_PER_BIT` cycles, then go to IDLE and assert `TX_Done` for exactly one cycle.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on bit expiry.
  - Cleared on every state entry from IDLE.
- `TX_Start` while `TX_Busy`=1 is ignored; there is no queueing.
- Changes to `TX_Data_in` after the accept edge have no effect on the current frame.
- Back-to-back frames:
  - `TX_Start`=1 in the cycle `TX_Done`=1 (first IDLE cycle) is accepted.
  - The next start bit then follows the stop bit with no extra idle cycles beyond that accept cycle.
- Reset mid-frame:
  - All outputs are forced to reset values immediately (asynchronously) and the frame is abandoned.
  - The line returns high; no `TX_Done` is issued.
- Reset values: `TX_out`=1, `TX_Busy`=0, `TX_Done`=0, state=IDLE, counters=0, shift register=0.

## Timing
- Let C = `CLKS_PER_BIT`, and let k be the edge that samples `TX_Start`=1 in IDLE.
- Start bit: `TX_out` is low from edge k through edge k+C.
- Data bit n (0..7): `TX_out` holds bit n from edge k+(n+1)C through edge k+(n+2)C.
- Stop bit:
  - Without parity: occupies edges k+9C..k+10C.
  - With parity: the parity bit occupies k+9C..k+10C and the stop bit occupies k+10C..k+11C.
- Frame length is 10C cycles (11C with parity).
- `TX_Busy` goes high after edge k and goes low after the final stop-bit edge (k+10C, or k+11C with parity).
- `TX_Done` is high for the single cycle following that edge.
- Latency from request to line falling is 1 cycle. Sustained throughput is 1 byte per 10C+1 cycles (11C+1 with parity).

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY_BIT state is compiled in. Each frame carries an even-parity bit between data and stop, giving 11C cycles per frame.
  - Undefined: the state, parity accumulator and related logic are absent. Frames are 8N1 at 10C cycles; DATA_BITS goes directly to STOP_BIT.

## Test plan
- Reset and idle:
  - Stimulus: hold `reset_b`=0, release, run 20 cycles with `TX_Start`=0.
  - Required: `TX_out`=1, `TX_Busy`=0 and `TX_Done`=0 throughout.
- Single byte, 8N1, C=4:
  - Stimulus: send 0x55.
  - Required: `TX_out` is 0,1,0,1,0,1,0,1,0,1, each held exactly 4 cycles starting 1 cycle after accept.
  - Required: `TX_Done` pulses once at cycle 41 after accept.
- Ignored request:
  - Stimulus: send 0xA3, pulse `TX_Start` with `TX_Data_in`=0xFF at cycle 12 of the frame.
  - Required: the line carries 0xA3 only (data bits 1,1,0,0,0,1,0,1) and there is no second frame.
- Back-to-back:
  - Stimulus: hold `TX_Start`=1 with 0x00 then 0xFF.
  - Required: the second start bit begins exactly 1 cycle after the first `TX_Done`, and two `TX_Done` pulses appear 41 cycles apart.
- Reset mid-frame:
  - Stimulus: assert `reset_b`=0 during data bit 3 of 0x0F.
  - Required: `TX_out`=1 and `TX_Busy`=0 in the same cycle, with no `TX_Done`.
  - Required: a subsequent 0x81 transmits correctly.
- Parity build (`UART_TX_PARITY_EN`, C=4):
  - Stimulus: send 0x07, then 0x03.
  - Required: the parity bit is 1, then 0, each followed by a stop bit.
  - Required: the frame is 44 cycles and `TX_Done` fires at cycle 45.
